// File: rtl/bdc_uart_pkg.sv
// -----------------------------------------------------------------------------
// bdc_uart_pkg
// Shared constants and FSM state encoding for the board's 9600-baud UART
// receive and transmit paths (uart_byte_rx now, uart_byte_tx later).
//
// Contents:
//   CLK_HZ, BAUD, OVS, DIV  default timing constants (49.152 MHz, 9600 baud,
//                           16x oversampling, 320 clk per oversample tick)
//   TICK_W                  width of the per-bit oversample tick counter
//   MID_TICK, LAST_TICK     tick_cnt values at the start-bit mid-sample and
//                           at the end of a full bit period
//   uart_state_t            IDLE/START/DATA/STOP/BREAK, 3-bit encoding
// -----------------------------------------------------------------------------
package bdc_uart_pkg;

  localparam int CLK_HZ = 49152000;
  localparam int BAUD   = 9600;
  localparam int OVS    = 16;
  localparam int DIV    = CLK_HZ / (BAUD * OVS);

  localparam int TICK_W = $clog2(OVS);

  // Start bit is confirmed half a bit after the falling edge was seen; every
  // later sample lands one full bit (OVS ticks) after the previous one.
  localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVS / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running divider producing a one-clk oversample tick every DIV clocks.
// The count restarts from zero at reset release, so the first tick arrives
// DIV clocks after reset_n rises.
//
// Ports:
//   clk      in  1  system clock
//   reset_n  in  1  asynchronous active-low reset
//   tick     out 1  high for one clk when the count reaches DIV-1
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int DIV = bdc_uart_pkg::DIV
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (count == CNT_MAX) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == CNT_MAX);

endmodule

// File: rtl/uart_byte_rx.sv
// -----------------------------------------------------------------------------
// uart_byte_rx
// 8N1 UART receiver. The asynchronous rxd line is synchronised, oversampled
// at 16 ticks per bit, the start bit is confirmed at mid-bit, eight data bits
// are shifted in LSB first and the stop bit is checked. Each good byte is
// offered on a valid/ready output register.
//
// Handshake: rx_valid rises when a byte completes and stays high, with
// rx_data stable, until a rising clk edge sees rx_valid && rx_ready; that
// edge clears rx_valid unless a new byte completes on the same edge, in
// which case the new byte loads and rx_valid stays high. rx_ready while
// rx_valid is low is ignored.
//
// Ports:
//   clk        in  1  system clock
//   reset_n    in  1  asynchronous active-low reset
//   rxd        in  1  asynchronous serial line, idle high
//   rx_data    out 8  received byte, held while rx_valid=1
//   rx_valid   out 1  byte available, held until accepted
//   rx_ready   in  1  consumer ready
//   frame_err  out 1  one-clk pulse: stop bit sampled low
//   overrun    out 1  one-clk pulse: byte completed while previous unaccepted
//   busy       out 1  FSM not in IDLE
//   dbg_state  out 3  current FSM state (uart_state_t encoding)
// -----------------------------------------------------------------------------
module uart_byte_rx #(
  parameter int CLK_HZ = bdc_uart_pkg::CLK_HZ,
  parameter int BAUD   = bdc_uart_pkg::BAUD
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy,
  output logic [2:0] dbg_state
);

  import bdc_uart_pkg::*;

  localparam int DIV = CLK_HZ / (BAUD * OVS);

  // ---------------------------------------------------------------------------
  // Input synchroniser; both stages reset to the idle line level so reset
  // release never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rxd_meta;
  logic rxd_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Oversample tick
  // ---------------------------------------------------------------------------
  logic tick;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  uart_state_t       state, state_n;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_n;
  logic [2:0]        bit_cnt, bit_cnt_n;
  logic [7:0]        shreg, shreg_n;
  logic              load_byte;
  logic              ferr_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    load_byte  = 1'b0;
    ferr_set   = 1'b0;

    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          if (!rxd_s) begin
            state_n    = ST_START;
            tick_cnt_n = '0;
          end
        end

        ST_START: begin
          if (tick_cnt == MID_TICK) begin
            if (!rxd_s) begin
              state_n    = ST_DATA;
              tick_cnt_n = '0;
              bit_cnt_n  = '0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              state_n = ST_IDLE;
            end
          end else begin
            tick_cnt_n = tick_cnt + TICK_W'(1);
          end
        end

        ST_DATA: begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt_n = '0;
            shreg_n    = {rxd_s, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
              state_n = ST_STOP;
            end else begin
              bit_cnt_n = bit_cnt + 3'd1;
            end
          end else begin
            tick_cnt_n = tick_cnt + TICK_W'(1);
          end
        end

        ST_STOP: begin
          if (tick_cnt == LAST_TICK) begin
            tick_cnt_n = '0;
            if (rxd_s) begin
              load_byte = 1'b1;
              state_n   = ST_IDLE;
            end else begin
              ferr_set = 1'b1;
              state_n  = ST_BREAK;
            end
          end else begin
            tick_cnt_n = tick_cnt + TICK_W'(1);
          end
        end

        ST_BREAK: begin
          // Hold off until the line returns high so a held-low line does not
          // produce a stream of 0x00 frames.
          if (rxd_s) begin
            state_n = ST_IDLE;
          end
        end

        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output register and handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_set;
      // A byte landing on the accept edge replaces the accepted one cleanly.
      overrun   <= load_byte && rx_valid && !rx_ready;
      if (load_byte) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule
